// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, data port, memory port and stall counters.
// The arbiter takes the slave modport; requesters and the memory model take master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  if_wait_cnt;
  logic [CNT_W-1:0]  d_wait_cnt;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we, if_wait_cnt, d_wait_cnt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we, if_wait_cnt, d_wait_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of fetch and data ports onto one memory: grant is combinational,
// response one cycle later; a waiting port simply sees ready=0 until it is granted.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_d;
  logic             r_resp_d;
  logic             r_resp_we;
  logic [CNT_W-1:0] r_if_cnt;
  logic [CNT_W-1:0] r_d_cnt;
  logic             w_gnt_if;
  logic             w_gnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_resp_d  <= 1'b0;
      r_resp_we <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_if || w_gnt_d) begin
        r_last_d  <= w_gnt_d;
        r_resp_d  <= w_gnt_d;
        r_resp_we <= w_gnt_d & bus.d_we;
      end
    end
  end

  // Everything is forced quiet while reset is low, including an in-flight response.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_if      = 1'b0;
    w_gnt_d       = 1'b0;
    bus.if_ready  = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.d_ready   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          w_gnt_d  = bus.d_req && (!bus.if_req || !r_last_d);
          w_gnt_if = bus.if_req && !w_gnt_d;
          if (w_gnt_d) begin
            bus.d_ready   = 1'b1;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_we    = bus.d_we;
            w_state_nxt   = RESP;
          end else if (w_gnt_if) begin
            bus.if_ready  = 1'b1;
            bus.mem_addr  = bus.if_addr;
            w_state_nxt   = RESP;
          end
        end
        RESP: begin
          if (r_resp_d) begin
            bus.d_rvalid = 1'b1;
            bus.d_rdata  = r_resp_we ? '0 : bus.mem_rdata;
          end else begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_if_cnt <= '0;
      r_d_cnt  <= '0;
    end else begin
      if (bus.if_req && !bus.if_ready && (r_if_cnt != '1))
        r_if_cnt <= r_if_cnt + CNT_W'(1);
      if (bus.d_req && !bus.d_ready && (r_d_cnt != '1))
        r_d_cnt <= r_d_cnt + CNT_W'(1);
    end
  end

  assign bus.if_wait_cnt = r_if_cnt;
  assign bus.d_wait_cnt  = r_d_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter, plus a narrow-counter instance for saturation.
module tb_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [15:0] if_cnt;
    logic [15:0] d_cnt;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  bus2 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  function automatic in_t mi(logic rst, logic ir, logic [31:0] ia, logic dr, logic dw,
                             logic [31:0] da, logic [31:0] dwd, logic [31:0] mr);
    in_t v;
    v.rst = rst; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd; v.mem_rdata = mr;
    return v;
  endfunction

  function automatic out_t mo(logic ir, logic iv, logic [31:0] ird, logic dr, logic dv,
                              logic [31:0] drd, logic [31:0] ma, logic [31:0] mwd,
                              logic mwe, logic [15:0] ic, logic [15:0] dc);
    out_t v;
    v.if_ready = ir; v.if_rvalid = iv; v.if_rdata = ird;
    v.d_ready = dr; v.d_rvalid = dv; v.d_rdata = drd;
    v.mem_addr = ma; v.mem_wdata = mwd; v.mem_we = mwe;
    v.if_cnt = ic; v.d_cnt = dc;
    return v;
  endfunction

  task automatic apply(input in_t v);
    reset          = v.rst;
    bus.if_req     = v.if_req;
    bus.if_addr    = v.if_addr;
    bus.d_req      = v.d_req;
    bus.d_we       = v.d_we;
    bus.d_addr     = v.d_addr;
    bus.d_wdata    = v.d_wdata;
    bus.mem_rdata  = v.mem_rdata;
  endtask

  task automatic sample(output out_t o);
    o.if_ready  = bus.if_ready;
    o.if_rvalid = bus.if_rvalid;
    o.if_rdata  = bus.if_rdata;
    o.d_ready   = bus.d_ready;
    o.d_rvalid  = bus.d_rvalid;
    o.d_rdata   = bus.d_rdata;
    o.mem_addr  = bus.mem_addr;
    o.mem_wdata = bus.mem_wdata;
    o.mem_we    = bus.mem_we;
    o.if_cnt    = bus.if_wait_cnt;
    o.d_cnt     = bus.d_wait_cnt;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  in_t  vin[$];
  out_t vexp[$];

  initial begin
    out_t       act;
    logic [3:0] prev_d;

    // Row fields: rst, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata
    // Expect:     if_rdy, if_rv, if_rdata, d_rdy, d_rv, d_rdata, mem_addr, mem_wdata, mem_we, if_cnt, d_cnt
    vin.push_back(mi(0, 1, 32'h100, 1, 0, 32'h200, 32'h77, 32'h0));
    vexp.push_back(mo(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
    vin.push_back(mi(1, 1, 32'h100, 1, 0, 32'h200, 32'h77, 32'h0));
    vexp.push_back(mo(0, 0, 32'h0, 1, 0, 32'h0, 32'h200, 32'h77, 0, 0, 0));
    vin.push_back(mi(1, 1, 32'h100, 1, 1, 32'h200, 32'h55, 32'hA5A50001));
    vexp.push_back(mo(0, 0, 32'h0, 0, 1, 32'hA5A50001, 32'h0, 32'h0, 0, 1, 0));
    vin.push_back(mi(1, 1, 32'h100, 1, 1, 32'h200, 32'h55, 32'h0));
    vexp.push_back(mo(1, 0, 32'h0, 0, 0, 32'h0, 32'h100, 32'h0, 0, 2, 1));
    vin.push_back(mi(1, 1, 32'h100, 1, 1, 32'h200, 32'h55, 32'hDEADBEEF));
    vexp.push_back(mo(0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0, 0, 2, 2));
    vin.push_back(mi(1, 1, 32'h100, 1, 1, 32'h200, 32'h55, 32'h0));
    vexp.push_back(mo(0, 0, 32'h0, 1, 0, 32'h0, 32'h200, 32'h55, 1, 3, 3));
    vin.push_back(mi(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678));
    vexp.push_back(mo(0, 0, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678));
    vexp.push_back(mo(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 1, 32'h100, 0, 0, 32'h0, 32'h0, 32'h0));
    vexp.push_back(mo(1, 0, 32'h0, 0, 0, 32'h0, 32'h100, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF));
    vexp.push_back(mo(0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 0, 32'h0, 1, 0, 32'h300, 32'h0, 32'h0));
    vexp.push_back(mo(0, 0, 32'h0, 1, 0, 32'h0, 32'h300, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 1, 32'h104, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D));
    vexp.push_back(mo(0, 0, 32'h0, 0, 1, 32'hCAFEF00D, 32'h0, 32'h0, 0, 4, 3));
    vin.push_back(mi(1, 1, 32'h104, 0, 0, 32'h0, 32'h0, 32'h0));
    vexp.push_back(mo(1, 0, 32'h0, 0, 0, 32'h0, 32'h104, 32'h0, 0, 5, 3));
    vin.push_back(mi(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF));
    vexp.push_back(mo(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 5, 3));
    vin.push_back(mi(1, 1, 32'h108, 1, 0, 32'h400, 32'h0, 32'h0));
    vexp.push_back(mo(0, 0, 32'h0, 1, 0, 32'h0, 32'h400, 32'h0, 0, 0, 0));
    vin.push_back(mi(1, 1, 32'h108, 1, 0, 32'h400, 32'h0, 32'h11));
    vexp.push_back(mo(0, 0, 32'h0, 0, 1, 32'h11, 32'h0, 32'h0, 0, 1, 0));
    vin.push_back(mi(1, 1, 32'h108, 0, 0, 32'h0, 32'h0, 32'h0));
    vexp.push_back(mo(1, 0, 32'h0, 0, 0, 32'h0, 32'h108, 32'h0, 0, 2, 1));

    bus2.if_req    = 1'b0;
    bus2.if_addr   = 32'h0;
    bus2.d_req     = 1'b0;
    bus2.d_we      = 1'b0;
    bus2.d_addr    = 32'h0;
    bus2.d_wdata   = 32'h0;
    bus2.mem_rdata = 32'h0;
    apply(mi(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0));
    @(posedge clk); #1;

    for (int i = 0; i < vin.size(); i++) begin
      apply(vin[i]);
      @(negedge clk);
      sample(act);
      check($sformatf("vec%0d", i), 256'(act), 256'(vexp[i]));
      @(posedge clk); #1;
    end

    // Saturation: both ports on the 4-bit instance keep requesting.
    apply(mi(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0));
    bus2.if_req  = 1'b1;
    bus2.if_addr = 32'h500;
    bus2.d_req   = 1'b1;
    bus2.d_addr  = 32'h600;
    prev_d       = 4'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("sat_mono%0d", c), 256'(bus2.d_wait_cnt >= prev_d), 256'(1));
      check($sformatf("sat_excl%0d", c), 256'(bus2.if_ready & bus2.d_ready), 256'(0));
      prev_d = bus2.d_wait_cnt;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sat_d_cnt", 256'(bus2.d_wait_cnt), 256'(15));
    check("sat_if_cnt", 256'(bus2.if_wait_cnt), 256'(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
